pipe_acc: RTL and testbench
===========================

# pipe_acc

Parametrised multi-channel streaming accumulator. Successor to the single fixed-width counter pipe: any number of independent channels, configurable data/accumulator widths and output latency, runtime wrap/saturate mode, per-beat clear-and-load, overflow reporting, and full valid/ready backpressure. Sits between a producer stream and a downstream consumer in the datapath.

## Interface
Parameters:
- W_DATA, 32, input sample width (signed, two's complement)
- W_ACC, 40, accumulator width; must be >= W_DATA
- N_CH, 4, number of independent channels (>= 1)
- LAT, 2, output pipeline depth in cycles (>= 1)
- W_CH, localparam, max(1, $clog2(N_CH))

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_reset  input  1  reset, asynchronous, active-high
- i_valid  input  1  input beat valid
- o_ready  output  1  block can accept a beat this cycle
- i_data  input  W_DATA  signed sample
- i_ch  input  W_CH  target channel
- i_clr  input  1  beat loads sext(i_data) instead of adding
- i_sat  input  1  1 = saturate, 0 = wrap (sampled per beat)
- o_valid  output  1  output beat valid
- i_ready  input  1  consumer accepts output beat
- o_acc  output  W_ACC  updated accumulator value of the beat
- o_ch  output  W_CH  channel of the beat
- o_ovf  output  1  this beat overflowed W_ACC
- o_ovf_sticky  output  N_CH  per-channel sticky overflow

## Operation
- Accept: beat accepted when i_valid && o_ready.
- Advance: `adv = !o_valid || i_ready`; o_ready = adv (combinational from i_ready and o_valid). All LAT stages shift together on adv; when !adv every stage holds. Bubbles are not collapsed.
- Update on accept, same edge, for channel c = i_ch:
  - x = sign-extend i_data to W_ACC; s = acc[c] + x, computed in W_ACC+1 bits.
  - Overflow = s does not fit W_ACC signed (top two bits of s differ).
  - i_clr=1: acc[c] := x, ovf=0, o_ovf_sticky[c] := 0.
  - i_clr=0, no overflow: acc[c] := s[W_ACC-1:0].
  - Overflow, i_sat=0: acc[c] := s[W_ACC-1:0] (wrap). Overflow, i_sat=1: acc[c] := +2^(W_ACC-1)-1 if s negative-overflowed upward (positive), else -2^(W_ACC-1).
  - Overflow sets o_ovf_sticky[c] := 1 (either mode).
- The new acc[c], c and ovf enter stage 1; they emerge on o_acc/o_ch/o_ovf at stage LAT.
- Successive beats to the same channel are back-to-back legal: the state update is single-cycle, so no hazard or forwarding is needed.
- i_ch >= N_CH (non-power-of-two N_CH): beat accepted, no accumulator or sticky change, output beat carries o_acc=0, o_ovf=0, o_ch=i_ch.
- Unaccepted cycles change no state.

## Timing
- Reset (async assert, sync release): all acc[] = 0, all stage valids 0, o_valid=0, o_acc=0, o_ch=0, o_ovf=0, o_ovf_sticky=0. In-flight beats are discarded; o_ready=1 in the first cycle after release.
- Latency: a beat accepted at edge t is presented on o_valid/o_acc from just after edge t+LAT-1 (LAT=1: registered output visible the cycle after accept), assuming no stall.
- Throughput: one beat per cycle while i_ready=1.
- Stall: o_valid=1 && i_ready=0 forces o_ready=0; output held stable until accepted. Output data is stable whenever o_valid=1 and not yet accepted.
- Simultaneous output accept and input accept in the same cycle: legal, the pipeline shifts and the new beat enters.
- Reset mid-stall: outputs drop to reset values immediately; no beat is replayed.

## Test plan
Config W_DATA=8, W_ACC=10, N_CH=3, LAT=2, i_ready=1 unless stated.
- Reset then ch0 beats +100 x6, i_sat=1 -> o_acc 100,200,300,400,500,511; last o_ovf=1, o_ovf_sticky=3'b001; first output 2 cycles after the first accept.
- Same sequence with i_sat=0 -> sixth o_acc = -424 (600-1024), o_ovf=1; then ch0 i_clr=1 data -5 -> o_acc=-5, o_ovf_sticky[0]=0.
- Interleave ch0 +1, ch1 -128, ch2 +7 for 4 rounds -> final o_acc 4, -512 (o_ovf=0), 28; channels independent; ch1 fifth -128 with i_sat=1 -> -512, o_ovf=1.
- Backpressure: stream 8 beats with i_ready toggling 1,0,0,1,... -> no beat lost or duplicated, o_acc stable while stalled, o_ready=0 exactly when o_valid && !i_ready.
- i_ch=3 beat data 50 -> output o_ch=3, o_acc=0, no channel changes.
- Assert i_reset while 2 beats in flight and stalled -> o_valid=0 immediately, all acc 0; next ch0 +9 -> o_acc=9.

Source files
------------

// File: rtl/pipe_acc.sv
// pipe_acc - multi-channel streaming accumulator with valid/ready handshake.
//
// Each accepted beat updates the accumulator of its channel in the accept
// cycle and sends the updated value down a LAT-deep output pipeline.
//
// Ports:
//   i_clk, i_reset         clock, async active-high reset
//   i_valid / o_ready      input handshake
//   i_data                 signed sample (W_DATA)
//   i_ch                   target channel (W_CH)
//   i_clr                  beat loads sext(i_data) instead of adding
//   i_sat                  1 = saturate on overflow, 0 = wrap
//   o_valid / i_ready      output handshake
//   o_acc, o_ch, o_ovf     updated accumulator, its channel, overflow flag
//   o_ovf_sticky           per-channel sticky overflow
module pipe_acc #(
  parameter int W_DATA = 32,
  parameter int W_ACC  = 40,
  parameter int N_CH   = 4,
  parameter int LAT    = 2,
  localparam int W_CH  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [W_DATA-1:0] i_data,
  input  logic        [W_CH-1:0]   i_ch,
  input  logic                     i_clr,
  input  logic                     i_sat,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [W_ACC-1:0]  o_acc,
  output logic        [W_CH-1:0]   o_ch,
  output logic                     o_ovf,
  output logic        [N_CH-1:0]   o_ovf_sticky
);

  // Sum does not fit W_ACC signed when its two top bits differ.
  function automatic logic add_ovf(input logic signed [W_ACC:0] s);
    return s[W_ACC] ^ s[W_ACC-1];
  endfunction

  // Clamp value for an overflowed sum: a non-negative extended sign means
  // the true result went above the positive limit.
  function automatic logic signed [W_ACC-1:0] sat_limit(input logic signed [W_ACC:0] s);
    if (!s[W_ACC]) return {1'b0, {(W_ACC-1){1'b1}}};
    else           return {1'b1, {(W_ACC-1){1'b0}}};
  endfunction

  logic adv;
  logic accept;

  logic signed [W_ACC-1:0] acc_q [N_CH];
  logic        [N_CH-1:0]  sticky_q;

  logic                    ch_ok;
  logic signed [W_ACC-1:0] acc_sel;
  logic signed [W_ACC-1:0] x;
  logic signed [W_ACC:0]   sum;
  logic                    ovf;
  logic signed [W_ACC-1:0] new_acc;
  logic signed [W_ACC-1:0] res_acc;
  logic                    res_ovf;

  logic        [LAT-1:0]   vld_q;
  logic signed [W_ACC-1:0] acc_p_q [LAT];
  logic        [W_CH-1:0]  ch_p_q  [LAT];
  logic        [LAT-1:0]   ovf_p_q;

  // The pipeline only needs the last stage to be free; interior bubbles are
  // deliberately not collapsed.
  assign adv     = !vld_q[LAT-1] || i_ready;
  assign o_ready = adv;
  assign accept  = i_valid && adv;

  // Update stage: select channel, add, detect overflow, saturate or wrap.
  always_comb begin
    ch_ok   = 1'b0;
    acc_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (i_ch == W_CH'(c)) begin
        ch_ok   = 1'b1;
        acc_sel = acc_q[c];
      end
    end
    x   = W_ACC'(i_data);
    sum = (W_ACC+1)'(acc_sel) + (W_ACC+1)'(x);
    ovf = add_ovf(sum);
    if (i_clr)            new_acc = x;
    else if (ovf && i_sat) new_acc = sat_limit(sum);
    else                  new_acc = sum[W_ACC-1:0];
    // Out-of-range channels pass through as an empty beat.
    res_acc = ch_ok ? new_acc : '0;
    res_ovf = ch_ok && !i_clr && ovf;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
      sticky_q <= '0;
    end else if (accept) begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_ch == W_CH'(c)) begin
          acc_q[c] <= new_acc;
          if (i_clr)    sticky_q[c] <= 1'b0;
          else if (ovf) sticky_q[c] <= 1'b1;
        end
      end
    end
  end

  // Output pipeline: stage 0 captures the update result, all stages shift
  // together on adv and hold otherwise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q   <= '0;
      ovf_p_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        acc_p_q[k] <= '0;
        ch_p_q[k]  <= '0;
      end
    end else if (adv) begin
      vld_q[0]   <= i_valid;
      acc_p_q[0] <= res_acc;
      ch_p_q[0]  <= i_ch;
      ovf_p_q[0] <= res_ovf;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k]   <= vld_q[k-1];
        acc_p_q[k] <= acc_p_q[k-1];
        ch_p_q[k]  <= ch_p_q[k-1];
        ovf_p_q[k] <= ovf_p_q[k-1];
      end
    end
  end

  assign o_valid      = vld_q[LAT-1];
  assign o_acc        = acc_p_q[LAT-1];
  assign o_ch         = ch_p_q[LAT-1];
  assign o_ovf        = ovf_p_q[LAT-1];
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_pipe_acc.sv
// Bench for pipe_acc at W_DATA=8, W_ACC=10, N_CH=3, LAT=2.
module tb_pipe_acc;

  localparam int W_DATA = 8;
  localparam int W_ACC  = 10;
  localparam int N_CH   = 3;
  localparam int LAT    = 2;
  localparam int W_CH   = 2;

  logic                     clk = 1'b0;
  logic                     i_reset = 1'b1;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic signed [W_DATA-1:0] i_data = '0;
  logic        [W_CH-1:0]   i_ch = '0;
  logic                     i_clr = 1'b0;
  logic                     i_sat = 1'b0;
  logic                     o_valid;
  logic                     i_ready = 1'b1;
  logic signed [W_ACC-1:0]  o_acc;
  logic        [W_CH-1:0]   o_ch;
  logic                     o_ovf;
  logic        [N_CH-1:0]   o_ovf_sticky;

  pipe_acc #(.W_DATA(W_DATA), .W_ACC(W_ACC), .N_CH(N_CH), .LAT(LAT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ch(i_ch), .i_clr(i_clr), .i_sat(i_sat),
    .o_valid(o_valid), .i_ready(i_ready), .o_acc(o_acc), .o_ch(o_ch),
    .o_ovf(o_ovf), .o_ovf_sticky(o_ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch; int data; bit clr; bit sat; int exp_acc; bit exp_ovf;
  } vec_t;
  typedef struct { int acc; int ch; bit ovf; } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void addv(int ch, int data, bit clr, bit sat, int ea, bit eo);
    vec_t v;
    v.ch = ch; v.data = data; v.clr = clr; v.sat = sat; v.exp_acc = ea; v.exp_ovf = eo;
    vt.push_back(v);
  endfunction

  // Drive one beat (called just after a rising edge); push its expected
  // output when the handshake is seen to complete.
  task automatic send(input vec_t v);
    exp_t e;
    bit   done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_ch    = W_CH'(v.ch);
    i_data  = W_DATA'(v.data);
    i_clr   = v.clr;
    i_sat   = v.sat;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (o_ready) begin
        e.acc = v.exp_acc; e.ch = v.ch; e.ovf = v.exp_ovf;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: beat ch=%0d never accepted", v.ch);
    end
    i_valid = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(vt[i]);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    exp_q.delete();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_acc", o_acc, 0);
    chk("rst_o_ch", o_ch, 0);
    chk("rst_o_ovf", o_ovf, 0);
    chk("rst_sticky", o_ovf_sticky, 0);
    chk("rst_o_ready", o_ready, 1);
  endtask

  // Output monitor / scoreboard.
  bit prev_stall = 1'b0;
  int held_acc   = 0;
  always @(negedge clk) begin
    if (!i_reset) begin
      exp_t e;
      chk("o_ready_rule", o_ready, (!o_valid || i_ready) ? 1 : 0);
      if (prev_stall && o_valid) chk("stall_hold", o_acc, held_acc);
      prev_stall = o_valid && !i_ready;
      held_acc   = o_acc;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_beat: unexpected o_acc=%0d o_ch=%0d", o_acc, o_ch);
        end else begin
          e = exp_q.pop_front();
          chk("o_acc", o_acc, e.acc);
          chk("o_ch", o_ch, e.ch);
          chk("o_ovf", o_ovf, e.ovf);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Backpressure pattern 1,0,0,1 repeating.
  bit       bp_en  = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int       bp_ph  = 0;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      i_ready = bp_pat[bp_ph];
      bp_ph   = (bp_ph + 1) % 4;
    end
  end

  int a0, b0, c0, d0, e0, f0, f1;

  initial begin
    // Saturating run on ch0.
    a0 = vt.size();
    addv(0, 100, 0, 1, 100, 0); addv(0, 100, 0, 1, 200, 0);
    addv(0, 100, 0, 1, 300, 0); addv(0, 100, 0, 1, 400, 0);
    addv(0, 100, 0, 1, 500, 0); addv(0, 100, 0, 1, 511, 1);
    // Wrapping run on ch0, then clear-and-load.
    b0 = vt.size();
    addv(0, 100, 0, 0, 100, 0); addv(0, 100, 0, 0, 200, 0);
    addv(0, 100, 0, 0, 300, 0); addv(0, 100, 0, 0, 400, 0);
    addv(0, 100, 0, 0, 500, 0); addv(0, 100, 0, 0, -424, 1);
    addv(0, -5, 1, 0, -5, 0);
    // Interleaved channels, then ch1 saturating low.
    c0 = vt.size();
    for (int r = 1; r <= 4; r++) begin
      addv(0, 1, 0, 1, r, 0);
      addv(1, -128, 0, 1, -128 * r, 0);
      addv(2, 7, 0, 1, 7 * r, 0);
    end
    addv(1, -128, 0, 1, -512, 1);
    // Backpressure stream on ch2.
    d0 = vt.size();
    for (int k = 1; k <= 8; k++) addv(2, 1, 0, 0, 28 + k, 0);
    // Out-of-range channel, then confirm channels untouched.
    e0 = vt.size();
    addv(3, 50, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 4, 0); addv(1, 0, 0, 0, -512, 0); addv(2, 0, 0, 0, 36, 0);
    // After mid-stall reset.
    f0 = vt.size();
    addv(0, 9, 0, 0, 9, 0); addv(1, 0, 0, 0, 0, 0); addv(2, 0, 0, 0, 0, 0);
    f1 = vt.size() - 1;

    @(posedge clk); #1;
    do_reset();

    send(vt[a0]);
    chk("lat_first_not_yet", o_valid, 0);
    send(vt[a0 + 1]);
    chk("lat_first_valid", o_valid, 1);
    chk("lat_first_acc", o_acc, 100);
    run_vecs(a0 + 2, b0 - 1);
    drain();
    chk("sat_sticky", o_ovf_sticky, 3'b001);

    do_reset();
    run_vecs(b0, b0 + 5);
    drain();
    chk("wrap_sticky", o_ovf_sticky, 3'b001);
    run_vecs(b0 + 6, b0 + 6);
    drain();
    chk("clr_sticky", o_ovf_sticky, 3'b000);

    do_reset();
    run_vecs(c0, d0 - 1);
    drain();
    chk("ch1_sticky", o_ovf_sticky, 3'b010);

    bp_en = 1'b1;
    run_vecs(d0, e0 - 1);
    drain();
    bp_en = 1'b0;
    @(posedge clk); #2;
    i_ready = 1'b1;

    run_vecs(e0, f0 - 1);
    drain();
    chk("oor_sticky", o_ovf_sticky, 3'b010);

    // Two beats in flight, stalled, then reset.
    @(posedge clk); #1;
    i_ready = 1'b0;
    i_valid = 1'b1; i_ch = 2'd0; i_data = 8'sd1; i_clr = 1'b0; i_sat = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("stalled_valid", o_valid, 1);
    chk("stalled_ready", o_ready, 0);
    i_reset = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_acc", o_acc, 0);
    chk("midrst_sticky", o_ovf_sticky, 0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    run_vecs(f0, f1);
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
